vnu_shuffled_pipe: RTL

Parametrised, pipelined variable-node unit for the shuffled LDPC decoder. Each accepted beat carries DV check-to-variable messages (sign-magnitude) and one channel LLR (two's complement). The block produces DV extrinsic variable-to-check messages plus the a-posteriori value (APP) and a hard decision, all in sign-magnitude. It sits between the CNU message memory and the VNU write-back path. It has valid/ready flow control and accepts one beat per cycle.

---
 rtl/vnu_pkg.sv | 43 ++++
 rtl/vnu_scale.sv | 23 ++
 rtl/vnu_shuffled_pipe.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/vnu_pkg.sv
// Shared types and helpers for the shuffled-decoder variable-node unit:
// scale modes, sign-magnitude/two's-complement conversion, saturation, width helpers.
package vnu_pkg;

    typedef enum logic [1:0] {
        SCALE_1    = 2'b00,
        SCALE_075  = 2'b01,
        SCALE_05   = 2'b10,
        SCALE_0875 = 2'b11
    } scaleMode_e;

    // Width of the running message sum; DV messages can never overflow it.
    function automatic int sumWidth(input int wMsg, input int dv);
        return wMsg + $clog2(dv) + 1;
    endfunction

    function automatic int addWidth(input int ws, input int wLlr);
        return ((ws > wLlr) ? ws : wLlr) + 1;
    endfunction

    // Negative zero has an all-zero magnitude and therefore maps to 0.
    function automatic int sm2tc(input logic [31:0] sm, input int w);
        logic [31:0] mag;
        mag = sm & ((32'd1 << (w - 1)) - 32'd1);
        return sm[w - 1] ? -int'(mag) : int'(mag);
    endfunction

    function automatic logic [31:0] tc2sm(input int v, input int w);
        logic [31:0] mag;
        mag = (v < 0) ? 32'(-v) : 32'(v);
        return (v < 0) ? (mag | (32'd1 << (w - 1))) : mag;
    endfunction

    // Symmetric saturation so the result is always representable in sign-magnitude.
    function automatic int sat_tc(input int v, input int w);
        int lim;
        lim = (1 << (w - 1)) - 1;
        if (v > lim)  return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

endpackage

// File: rtl/vnu_scale.sv
// Combinational shift-add message scaler (x1, x0.75, x0.5, x0.875).
// Arithmetic shifts floor toward minus infinity.
module vnu_scale
    import vnu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic signed [W-1:0] x,
    input  scaleMode_e          mode,
    output logic signed [W-1:0] y
);

    // NOTE: every mode, including the default arm, assigns y, so no latch is inferred.
    always_comb begin
        case (mode)
            SCALE_075:  y = x - (x >>> 2);
            SCALE_05:   y = x >>> 1;
            SCALE_0875: y = x - (x >>> 3);
            default:    y = x;
        endcase
    end

endmodule

// File: rtl/vnu_shuffled_pipe.sv
// Three-stage pipelined variable-node unit with valid/ready flow control.
// Define VNU_SCALE_EN to honour i_scale; otherwise every value passes at x1.
module vnu_shuffled_pipe
    import vnu_pkg::*;
#(
    parameter int DV    = 4,
    parameter int W_MSG = 6,
    parameter int W_LLR = 9,
    parameter int W_OUT = 10,
    parameter int W_TAG = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [0:DV-1][W_MSG-1:0]    i_data,
    input  logic [W_LLR-1:0]            i_llr,
    input  logic [1:0]                  i_scale,
    input  logic [W_TAG-1:0]            i_tag,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [0:DV][W_OUT-1:0]      o_data,
    output logic                        o_hard,
    output logic [W_TAG-1:0]            o_tag
);

    localparam int WS = sumWidth(W_MSG, DV);
    localparam int WA = addWidth(WS, W_LLR);

    logic v1, v2;
    logic load1, load2, load3;

    logic signed [WS-1:0]    msgIn [0:DV-1];
    logic signed [WS-1:0]    sumIn;
    scaleMode_e              modeIn;

    logic signed [WS-1:0]    msg1 [0:DV-1];
    logic signed [WS-1:0]    sum1;
    logic signed [W_LLR-1:0] llr1;
    logic [W_TAG-1:0]        tag1;
    scaleMode_e              mode1;

    logic signed [WS-1:0]    extRaw [0:DV];
    logic signed [WS-1:0]    extScaled [0:DV];

    logic signed [WS-1:0]    ext2 [0:DV];
    logic signed [W_LLR-1:0] llr2;
    logic [W_TAG-1:0]        tag2;

    logic signed [WA-1:0]    addVal;
    logic [0:DV][W_OUT-1:0]  outData;
    logic                    outHard;

    // A stage may load when it is empty or its successor is taking its beat this cycle.
    assign load3   = !o_valid || i_ready;
    assign load2   = !v2 || load3;
    assign load1   = !v1 || load2;
    assign o_ready = load1;

`ifdef VNU_SCALE_EN
    assign modeIn = scaleMode_e'(i_scale);
`else
    logic unusedScale;
    assign modeIn      = SCALE_1;
    assign unusedScale = ^i_scale;
`endif

    always_comb begin
        sumIn = '0;
        for (int i = 0; i < DV; i++) begin
            msgIn[i] = WS'(sm2tc(32'(i_data[i]), W_MSG));
            sumIn    = sumIn + msgIn[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (load1) v1 <= i_valid;
            if (load2) v2 <= v1;
        end
    end

    // NOTE: datapath registers have no reset; the stage valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (load1 && i_valid) begin
            msg1  <= msgIn;
            sum1  <= sumIn;
            llr1  <= i_llr;
            tag1  <= i_tag;
            mode1 <= modeIn;
        end
    end

    // Extrinsic values exclude their own message; the last lane is the full sum for the APP.
    always_comb begin
        for (int i = 0; i < DV; i++) begin
            extRaw[i] = sum1 - msg1[i];
        end
        extRaw[DV] = sum1;
    end

    for (genvar g = 0; g <= DV; g++) begin : genScale
        vnu_scale #(.W(WS)) uScale (
            .x    (extRaw[g]),
            .mode (mode1),
            .y    (extScaled[g])
        );
    end

    always_ff @(posedge clk) begin
        if (load2 && v1) begin
            ext2 <= extScaled;
            llr2 <= llr1;
            tag2 <= tag1;
        end
    end

    always_comb begin
        addVal  = '0;
        outData = '0;
        for (int i = 0; i <= DV; i++) begin
            addVal     = WA'(ext2[i]) + WA'(llr2);
            outData[i] = W_OUT'(tc2sm(sat_tc(int'(addVal), W_OUT), W_OUT));
        end
    end

    // tc2sm never sets the sign bit for zero, so a zero APP reads as positive.
    assign outHard = outData[DV][W_OUT-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_hard  <= 1'b0;
            o_tag   <= '0;
        end else if (load3) begin
            o_valid <= v2;
            if (v2) begin
                o_data <= outData;
                o_hard <= outHard;
                o_tag  <= tag2;
            end
        end
    end

endmodule
